// File: rtl/write_back_pipe_if.sv
// Handshake and register-file bundle between the memory stage, the write-back
// stage and the register-file write port.
interface write_back_pipe_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM       = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int COUNT_WIDTH   = 64
);
  localparam int REG_ADDR_WIDTH = $clog2(REG_NUM);

  logic                      i_valid;
  logic                      o_ready;
  logic                      i_flush;
  logic                      i_rf_wr_en;
  logic [REG_ADDR_WIDTH-1:0] i_rf_wr_addr;
  logic [DATA_WIDTH-1:0]     i_alu_result;
  logic                      i_load_en;
  logic [31:0]               i_load_data;
  logic [2:0]                i_load_funct3;
  logic [ADDRESS_WIDTH-1:0]  i_pc;
  logic                      i_ecall;

  logic                      o_rf_wr_en;
  logic [REG_ADDR_WIDTH-1:0] o_rf_wr_addr;
  logic [DATA_WIDTH-1:0]     o_rf_wr_data;
  logic [ADDRESS_WIDTH-1:0]  o_pc;
  logic                      o_retire;
  logic                      o_ecall;
  logic                      o_halt;
  logic [COUNT_WIDTH-1:0]    o_retire_count;

  // Upstream / observer side.
  modport master (
    output i_valid, i_flush, i_rf_wr_en, i_rf_wr_addr, i_alu_result,
           i_load_en, i_load_data, i_load_funct3, i_pc, i_ecall,
    input  o_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_pc,
           o_retire, o_ecall, o_halt, o_retire_count
  );

  // Write-back stage side.
  modport slave (
    input  i_valid, i_flush, i_rf_wr_en, i_rf_wr_addr, i_alu_result,
           i_load_en, i_load_data, i_load_funct3, i_pc, i_ecall,
    output o_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_pc,
           o_retire, o_ecall, o_halt, o_retire_count
  );
endinterface

// File: rtl/write_back_pipe.sv
// Write-back stage: one-entry register behind a valid/ready handshake with load
// formatting, x0 write suppression, retire counting and sticky ecall halt.
module write_back_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM       = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int COUNT_WIDTH   = 64
) (
  input logic               i_clk,
  input logic               i_rst,
  write_back_pipe_if.slave  bus
);
  localparam int REG_ADDR_WIDTH = $clog2(REG_NUM);

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LBU = 3'b100,
    LHU = 3'b101
  } load_kind_e;

  logic                      vld_q;
  logic                      wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [ADDRESS_WIDTH-1:0]  pc_q;
  logic                      ecall_q;
  logic                      halt_q;
  logic [COUNT_WIDTH-1:0]    count_q;

  logic                      ready;
  logic                      accept;
  logic [1:0]                off;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;
  logic [DATA_WIDTH-1:0]     wr_data_d;

  // An ecall in the register blocks the next instruction so nothing younger
  // can slip in ahead of the halt.
  assign ready  = ~halt_q & ~(vld_q & ecall_q);
  assign accept = bus.i_valid & ready & ~bus.i_flush;
  assign off    = bus.i_alu_result[1:0];

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    byte_sel  = bus.i_load_data[8*off +: 8];
    half_sel  = off[1] ? bus.i_load_data[31:16] : bus.i_load_data[15:0];
    wr_data_d = bus.i_alu_result;
    if (bus.i_load_en) begin
      case (load_kind_e'(bus.i_load_funct3))
        LB:      wr_data_d = DATA_WIDTH'($signed(byte_sel));
        LBU:     wr_data_d = DATA_WIDTH'(byte_sel);
        LH:      wr_data_d = DATA_WIDTH'($signed(half_sel));
        LHU:     wr_data_d = DATA_WIDTH'(half_sel);
        default: wr_data_d = DATA_WIDTH'($signed(bus.i_load_data));
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q   <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
      ecall_q <= 1'b0;
      halt_q  <= 1'b0;
      count_q <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        wr_en_q <= bus.i_rf_wr_en;
        addr_q  <= bus.i_rf_wr_addr;
        data_q  <= wr_data_d;
        pc_q    <= bus.i_pc;
        ecall_q <= bus.i_ecall;
      end
      if (vld_q) count_q <= count_q + 1'b1;
      if (vld_q & ecall_q) halt_q <= 1'b1;
    end
  end

  assign bus.o_ready        = ready;
  assign bus.o_rf_wr_en     = vld_q & wr_en_q & (addr_q != '0) & ~ecall_q;
  assign bus.o_rf_wr_addr   = addr_q;
  assign bus.o_rf_wr_data   = data_q;
  assign bus.o_pc           = pc_q;
  assign bus.o_retire       = vld_q;
  assign bus.o_ecall        = vld_q & ecall_q;
  assign bus.o_halt         = halt_q;
  assign bus.o_retire_count = count_q;
endmodule

// File: tb/tb_write_back_pipe.sv
// Directed bench for write_back_pipe; a narrow retire counter exposes the wrap.
module tb_write_back_pipe;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int AW = 32;
  localparam int CW = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  write_back_pipe_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  write_back_pipe #(.DATA_WIDTH(DW), .REG_NUM(RN), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic idle();
    bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_rf_wr_en = 1'b0; bus.i_rf_wr_addr = '0;
    bus.i_alu_result = '0; bus.i_load_en = 1'b0; bus.i_load_data = '0;
    bus.i_load_funct3 = '0; bus.i_pc = '0; bus.i_ecall = 1'b0;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc,
                       input logic ld, input logic [2:0] f3, input logic [31:0] ldata,
                       input logic ec, input logic fl);
    bus.i_valid = 1'b1; bus.i_flush = fl; bus.i_rf_wr_en = 1'b1; bus.i_rf_wr_addr = rd;
    bus.i_alu_result = alu; bus.i_load_en = ld; bus.i_load_funct3 = f3;
    bus.i_load_data = ldata; bus.i_pc = pc; bus.i_ecall = ec;
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; #2;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic expect_idle_outputs(input string tag);
    compared++; if (bus.o_rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL %s wr_en: got %b want 0", tag, bus.o_rf_wr_en); end
    compared++; if (bus.o_rf_wr_addr !== 5'd0) begin mismatched++; $display("FAIL %s wr_addr: got %0d want 0", tag, bus.o_rf_wr_addr); end
    compared++; if (bus.o_rf_wr_data !== 32'd0) begin mismatched++; $display("FAIL %s wr_data: got %h want 0", tag, bus.o_rf_wr_data); end
    compared++; if (bus.o_pc !== 32'd0) begin mismatched++; $display("FAIL %s pc: got %h want 0", tag, bus.o_pc); end
    compared++; if (bus.o_retire !== 1'b0) begin mismatched++; $display("FAIL %s retire: got %b want 0", tag, bus.o_retire); end
    compared++; if (bus.o_ecall !== 1'b0) begin mismatched++; $display("FAIL %s ecall: got %b want 0", tag, bus.o_ecall); end
    compared++; if (bus.o_halt !== 1'b0) begin mismatched++; $display("FAIL %s halt: got %b want 0", tag, bus.o_halt); end
    compared++; if (bus.o_retire_count !== 4'd0) begin mismatched++; $display("FAIL %s count: got %0d want 0", tag, bus.o_retire_count); end
    compared++; if (bus.o_ready !== 1'b1) begin mismatched++; $display("FAIL %s ready: got %b want 1", tag, bus.o_ready); end
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    expect_idle_outputs("reset");
  endtask

  task automatic test_alu();
    offer(5'd5, 32'h0000_1234, 32'h10, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    compared++; if (bus.o_rf_wr_en !== 1'b1) begin mismatched++; $display("FAIL alu wr_en: got %b want 1", bus.o_rf_wr_en); end
    compared++; if (bus.o_rf_wr_addr !== 5'd5) begin mismatched++; $display("FAIL alu addr: got %0d want 5", bus.o_rf_wr_addr); end
    compared++; if (bus.o_rf_wr_data !== 32'h0000_1234) begin mismatched++; $display("FAIL alu data: got %h want 00001234", bus.o_rf_wr_data); end
    compared++; if (bus.o_retire !== 1'b1) begin mismatched++; $display("FAIL alu retire: got %b want 1", bus.o_retire); end
    compared++; if (bus.o_pc !== 32'h10) begin mismatched++; $display("FAIL alu pc: got %h want 10", bus.o_pc); end
    compared++; if (bus.o_retire_count !== 4'd0) begin mismatched++; $display("FAIL alu count_before: got %0d want 0", bus.o_retire_count); end
    tick();
    compared++; if (bus.o_retire_count !== 4'd1) begin mismatched++; $display("FAIL alu count_after: got %0d want 1", bus.o_retire_count); end
    compared++; if (bus.o_retire !== 1'b0) begin mismatched++; $display("FAIL alu drained: got %b want 0", bus.o_retire); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
    logic [1:0]  ofs [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd1};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      offer(5'd7, {30'h100, ofs[i]}, 32'h40 + 32'(i), 1'b1, f3[i], 32'h80FF_7F01, 1'b0, 1'b0);
      tick();
      compared++;
      if (bus.o_rf_wr_data !== exp[i]) begin
        mismatched++; $display("FAIL load%0d f3=%b off=%0d: got %h want %h", i, f3[i], ofs[i], bus.o_rf_wr_data, exp[i]);
      end
    end
    idle();
    tick();
    compared++; if (bus.o_retire_count !== 4'd6) begin mismatched++; $display("FAIL loads count: got %0d want 6", bus.o_retire_count); end
  endtask

  task automatic test_x0();
    offer(5'd0, 32'hDEAD_BEEF, 32'h80, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    compared++; if (bus.o_rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL x0 wr_en: got %b want 0", bus.o_rf_wr_en); end
    compared++; if (bus.o_retire !== 1'b1) begin mismatched++; $display("FAIL x0 retire: got %b want 1", bus.o_retire); end
    tick();
    compared++; if (bus.o_retire_count !== 4'd7) begin mismatched++; $display("FAIL x0 count: got %0d want 7", bus.o_retire_count); end
  endtask

  task automatic test_back_to_back_flush();
    int retires = 0;
    int pc_leak = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) offer(5'd1 + 5'(i), 32'(i), 32'h200 + 32'(4 * i), 1'b0, 3'b000, 32'h0, 1'b0, i == 1);
      else idle();
      tick();
      if (bus.o_retire === 1'b1) retires++;
      if (bus.o_pc === 32'h204) pc_leak++;
    end
    compared++; if (retires !== 3) begin mismatched++; $display("FAIL flush retires: got %0d want 3", retires); end
    compared++; if (pc_leak !== 0) begin mismatched++; $display("FAIL flush pc_leak: got %0d cycles want 0", pc_leak); end
    compared++; if (bus.o_retire_count !== 4'd3) begin mismatched++; $display("FAIL flush count: got %0d want 3", bus.o_retire_count); end
  endtask

  task automatic test_ecall_halt();
    do_reset();
    offer(5'd3, 32'h0, 32'h100, 1'b0, 3'b000, 32'h0, 1'b1, 1'b0);
    tick();
    offer(5'd9, 32'h55, 32'h104, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
    compared++; if (bus.o_ecall !== 1'b1) begin mismatched++; $display("FAIL ecall flag: got %b want 1", bus.o_ecall); end
    compared++; if (bus.o_ready !== 1'b0) begin mismatched++; $display("FAIL ecall ready: got %b want 0", bus.o_ready); end
    compared++; if (bus.o_pc !== 32'h100) begin mismatched++; $display("FAIL ecall pc: got %h want 100", bus.o_pc); end
    compared++; if (bus.o_rf_wr_en !== 1'b0) begin mismatched++; $display("FAIL ecall wr_en: got %b want 0", bus.o_rf_wr_en); end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (bus.o_halt !== 1'b1 || bus.o_ecall !== 1'b0 || bus.o_retire !== 1'b0 || bus.o_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL halted%0d: got halt=%b ecall=%b retire=%b ready=%b want 1 0 0 0",
                 i, bus.o_halt, bus.o_ecall, bus.o_retire, bus.o_ready);
      end
    end
    idle();
    compared++; if (bus.o_retire_count !== 4'd1) begin mismatched++; $display("FAIL ecall count: got %0d want 1", bus.o_retire_count); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    compared++; if (bus.o_halt !== 1'b0 || bus.o_ready !== 1'b1) begin mismatched++; $display("FAIL wrap reset_halt: got halt=%b ready=%b want 0 1", bus.o_halt, bus.o_ready); end
    for (int k = 1; k <= 16; k++) begin
      offer(5'd2, 32'(k), 32'h300 + 32'(4 * k), 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
      tick();
    end
    idle();
    compared++; if (bus.o_retire_count !== 4'd15) begin mismatched++; $display("FAIL wrap all_ones: got %0d want 15", bus.o_retire_count); end
    tick();
    compared++; if (bus.o_retire_count !== 4'd0) begin mismatched++; $display("FAIL wrap zero: got %0d want 0", bus.o_retire_count); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      offer(5'd4, 32'hABCD_0000 + 32'(k), 32'h400 + 32'(4 * k), 1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
      tick();
    end
    #2;
    i_rst = 1'b1;
    #1;
    idle();
    #0;
    expect_idle_outputs("async_reset");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  initial begin
    idle();
    test_reset();
    test_alu();
    test_loads();
    test_x0();
    test_back_to_back_flush();
    test_ecall_halt();
    test_counter_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
